// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder: FSM state encoding, command codes,
// default widths and the fill byte sent when a read times out.
package spi_pkg;

    localparam int FRAME_W_DEF     = 10;
    localparam int DATA_W_DEF      = 8;
    localparam int TIMEOUT_CYC_DEF = 16;

    // Byte returned to the initiator when the local side never answers a read.
    localparam logic [7:0] TIMEOUT_FILL = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_WAIT_TX,
        ST_SEND,
        ST_WAIT_SS
    } state_e;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    // Only read-data frames need a byte returned on MISO; the rest are decoded locally.
    function automatic logic is_read_cmd(input logic [1:0] cmd);
        return cmd == CMD_RD_DATA;
    endfunction

endpackage

// File: rtl/spi_slave_tx_shifter.sv
// Parallel-in / serial-out shifter for MISO read data, MSB first.
// A load presents the first bit on the next cycle; each shift-enabled cycle then
// advances one bit until DATA_W bits have been shown, after which miso/miso_valid
// return to 0. done is high while the last bit is on the line. abort clears everything.
module spi_slave_tx_shifter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift_en,
    input  logic              abort,
    input  logic [DATA_W-1:0] load_data,
    output logic              miso,
    output logic              miso_valid,
    output logic              done
);

    localparam int               CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              miso_q, miso_d;
    logic              valid_q, valid_d;

    // Next-state for the shift register, bit counter and registered MISO outputs.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        shift_d = shift_q;
        cnt_d   = cnt_q;
        miso_d  = miso_q;
        valid_d = valid_q;
        if (abort) begin
            shift_d = '0;
            cnt_d   = '0;
            miso_d  = 1'b0;
            valid_d = 1'b0;
        end else if (load) begin
            miso_d  = load_data[DATA_W-1];
            shift_d = {load_data[DATA_W-2:0], 1'b0};
            cnt_d   = CNT_W'(1);
            valid_d = 1'b1;
        end else if (shift_en && valid_q) begin
            if (cnt_q == LAST_CNT) begin
                shift_d = '0;
                cnt_d   = '0;
                miso_d  = 1'b0;
                valid_d = 1'b0;
            end else begin
                miso_d  = shift_q[DATA_W-1];
                shift_d = {shift_q[DATA_W-2:0], 1'b0};
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end
    end

    // Shifter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
            miso_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            miso_q  <= miso_d;
            valid_q <= valid_d;
        end
    end

    assign miso       = miso_q;
    assign miso_valid = valid_q;
    assign done       = valid_q && (cnt_q == LAST_CNT);

endmodule

// File: rtl/spi_slave.sv
// SPI responder for the 10-bit command/data frame protocol on the system clock.
// Receives MOSI frames MSB first, reports them to the local side, and for
// read-data commands returns one byte on MISO with a per-bit valid.
// Optional build macro: SPI_SLAVE_RD_TIMEOUT_EN -- when defined, a read that the
// local side does not answer within TIMEOUT_CYC cycles returns the fill byte 8'hFF.
module spi_slave
    import spi_pkg::*;
#(
    parameter int FRAME_W     = FRAME_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic               i_spi_slave_clk,
    input  logic               i_spi_slave_rst_n,
    input  logic               i_spi_slave_ss_bar,
    input  logic               i_spi_slave_mosi,
    output logic               o_spi_slave_miso,
    output logic               o_spi_slave_miso_valid,
    output logic               o_spi_slave_sready,
    output logic               o_spi_slave_busy,
    output logic [FRAME_W-1:0] o_spi_slave_rx_data,
    output logic               o_spi_slave_rx_valid,
    input  logic [DATA_W-1:0]  i_spi_slave_tx_data,
    input  logic               i_spi_slave_tx_valid
);

`ifdef SPI_SLAVE_RD_TIMEOUT_EN
    localparam bit RD_TIMEOUT_EN = 1'b1;
`else
    localparam bit RD_TIMEOUT_EN = 1'b0;
`endif

    localparam int                  RX_CNT_W = $clog2(FRAME_W);
    localparam logic [RX_CNT_W-1:0] LAST_BIT = RX_CNT_W'(FRAME_W - 1);
    localparam int                  WAIT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WAIT_W-1:0]   WAIT_MAX = WAIT_W'(TIMEOUT_CYC - 1);

    state_e              state_q, state_d;
    logic [RX_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0]  rx_shift_q, rx_shift_d;
    logic [FRAME_W-1:0]  rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;

    logic [FRAME_W-1:0]  frame_next;
    logic                timeout_hit;
    logic                tx_load, tx_abort, tx_done;
    logic [DATA_W-1:0]   tx_load_data;

    // Frame as it stands once the current MOSI bit is shifted in.
    assign frame_next  = {rx_shift_q[FRAME_W-2:0], i_spi_slave_mosi};
    // With the timeout compiled out this is constant 0 and the wait counter is pruned.
    assign timeout_hit = RD_TIMEOUT_EN && (wait_cnt_q == WAIT_MAX);

    // FSM next-state, receive path and shifter control.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rx_shift_d   = rx_shift_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        wait_cnt_d   = '0;
        tx_load      = 1'b0;
        tx_abort     = 1'b0;
        tx_load_data = i_spi_slave_tx_data;
        unique case (state_q)
            ST_IDLE: begin
                // Selection only arms the receiver; the first bit is taken next cycle.
                bit_cnt_d = '0;
                if (!i_spi_slave_ss_bar) state_d = ST_RECV;
            end
            ST_RECV: begin
                if (i_spi_slave_ss_bar) begin
                    // Short frame: drop it without touching rx_data.
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    rx_shift_d = frame_next;
                    bit_cnt_d  = bit_cnt_q + RX_CNT_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d  = '0;
                        rx_data_d  = frame_next;
                        rx_valid_d = 1'b1;
                        state_d    = is_read_cmd(frame_next[FRAME_W-1 -: 2]) ? ST_WAIT_TX : ST_WAIT_SS;
                    end
                end
            end
            ST_WAIT_TX: begin
                if (i_spi_slave_ss_bar) begin
                    tx_abort = 1'b1;
                    state_d  = ST_IDLE;
                end else if (i_spi_slave_tx_valid) begin
                    tx_load = 1'b1;
                    state_d = ST_SEND;
                end else if (timeout_hit) begin
                    tx_load      = 1'b1;
                    tx_load_data = DATA_W'(TIMEOUT_FILL);
                    state_d      = ST_SEND;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_SEND: begin
                if (i_spi_slave_ss_bar) begin
                    tx_abort = 1'b1;
                    state_d  = ST_IDLE;
                end else if (tx_done) begin
                    state_d = ST_WAIT_SS;
                end
            end
            ST_WAIT_SS: begin
                if (i_spi_slave_ss_bar) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and receive-path registers.
    always_ff @(posedge i_spi_slave_clk or negedge i_spi_slave_rst_n) begin
        // NOTE: rx_data is a plain output register, not a memory, so it is reset like the rest.
        if (!i_spi_slave_rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    spi_slave_tx_shifter #(
        .DATA_W (DATA_W)
    ) u_tx_shifter (
        .clk        (i_spi_slave_clk),
        .rst_n      (i_spi_slave_rst_n),
        .load       (tx_load),
        .shift_en   (state_q == ST_SEND),
        .abort      (tx_abort),
        .load_data  (tx_load_data),
        .miso       (o_spi_slave_miso),
        .miso_valid (o_spi_slave_miso_valid),
        .done       (tx_done)
    );

    assign o_spi_slave_sready   = (state_q == ST_IDLE) && i_spi_slave_ss_bar;
    assign o_spi_slave_busy     = (state_q != ST_IDLE);
    assign o_spi_slave_rx_data  = rx_data_q;
    assign o_spi_slave_rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: directed frames; expected rx frames and MISO bits go into a
// scoreboard queue and a negedge monitor pops one entry per presented output.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ss_bar;
    logic       mosi;
    logic       miso;
    logic       miso_valid;
    logic       sready;
    logic       busy;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         is_rx;
        logic [9:0] val;
    } exp_t;

    exp_t sb_q[$];

    spi_slave dut (
        .i_spi_slave_clk        (clk),
        .i_spi_slave_rst_n      (rst_n),
        .i_spi_slave_ss_bar     (ss_bar),
        .i_spi_slave_mosi       (mosi),
        .o_spi_slave_miso       (miso),
        .o_spi_slave_miso_valid (miso_valid),
        .o_spi_slave_sready     (sready),
        .o_spi_slave_busy       (busy),
        .o_spi_slave_rx_data    (rx_data),
        .o_spi_slave_rx_valid   (rx_valid),
        .i_spi_slave_tx_data    (tx_data),
        .i_spi_slave_tx_valid   (tx_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_rx(input logic [9:0] frame);
        exp_t e;
        e.is_rx = 1'b1;
        e.val   = frame;
        sb_q.push_back(e);
    endtask

    task automatic push_bits(input logic [7:0] b, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.is_rx = 1'b0;
            e.val   = {9'd0, b[7-i]};
            sb_q.push_back(e);
        end
    endtask

    task automatic sb_pop(input bit is_rx, input logic [9:0] act, input string name);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected output %0h, nothing expected", name, act);
        end else begin
            e = sb_q.pop_front();
            if (e.is_rx != is_rx || e.val !== act) begin
                errors++;
                $display("FAIL %s: got %0h (rx=%0d) expected %0h (rx=%0d)",
                         name, act, is_rx, e.val, e.is_rx);
            end
        end
    endtask

    // Monitor: every rx_valid or miso_valid cycle consumes one scoreboard entry.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (rx_valid)   sb_pop(1'b1, rx_data, "rx_frame");
            if (miso_valid) sb_pop(1'b0, {9'd0, miso}, "miso_bit");
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Select, then one MOSI bit per cycle MSB first; returns just after rx_valid rises.
    task automatic send_frame(input logic [9:0] frame);
        ss_bar = 1'b0;
        tick();
        for (int i = 9; i >= 0; i--) begin
            mosi = frame[i];
            tick();
        end
        mosi = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        ss_bar   = 1'b1;
        mosi     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        #12;
        check("rst_miso",       miso,       1'b0);
        check("rst_miso_valid", miso_valid, 1'b0);
        check("rst_rx_data",    rx_data,    10'h000);
        check("rst_rx_valid",   rx_valid,   1'b0);
        check("rst_busy",       busy,       1'b0);
        check("rst_sready",     sready,     1'b1);
        rst_n = 1'b1;
        tick();

        // Write-address frame: rx only, no MISO traffic.
        push_rx(10'h0A5);
        send_frame(10'h0A5);
        check("wr_rx_data", rx_data, 10'h0A5);
        check("wr_busy",    busy,    1'b1);
        ss_bar = 1'b1;
        tick();
        check("wr_sready", sready, 1'b1);
        check("wr_busy_0", busy,   1'b0);

        // Read-data frame, tx_valid two cycles after rx_valid.
        push_rx(10'h307);
        push_bits(8'h3C, 8);
        send_frame(10'h307);
        check("rd_wait_sready", sready,     1'b0);
        check("rd_wait_mv",     miso_valid, 1'b0);
        tick();
        tick();
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        tick();
        tx_valid = 1'b0;
        check("rd_first_bit_valid", miso_valid, 1'b1);
        repeat (7) tick();
        check("rd_last_bit_valid", miso_valid, 1'b1);
        tick();
        check("rd_after_mv",   miso_valid, 1'b0);
        check("rd_after_miso", miso,       1'b0);
        check("rd_wait_ss",    busy,       1'b1);
        ss_bar = 1'b1;
        tick();
        check("rd_idle_sready", sready, 1'b1);

        // Short frame: deselect after 5 bits.
        ss_bar = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            mosi = (i == 1 || i == 2 || i == 4);
            tick();
        end
        ss_bar = 1'b1;
        tick();
        check("short_rx_data", rx_data,  10'h307);
        check("short_rx_vld",  rx_valid, 1'b0);
        check("short_busy",    busy,     1'b0);
        check("short_sready",  sready,   1'b1);

        // Read with zero-wait tx_valid, aborted on the 3rd MISO bit.
        push_rx(10'h3AB);
        push_bits(8'hA5, 3);
        send_frame(10'h3AB);
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        tick();
        tx_valid = 1'b0;
        tick();
        tick();
        ss_bar = 1'b1;
        tick();
        check("abort_mv",     miso_valid, 1'b0);
        check("abort_miso",   miso,       1'b0);
        check("abort_busy",   busy,       1'b0);
        check("abort_sready", sready,     1'b1);
        check("abort_rxdata", rx_data,    10'h3AB);

        // Stray tx_valid in IDLE.
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        tick();
        tx_valid = 1'b0;
        tick();
        check("stray_busy", busy,       1'b0);
        check("stray_mv",   miso_valid, 1'b0);

        // Reset during the 4th MISO bit, then a clean frame.
        push_rx(10'h3C0);
        push_bits(8'h96, 4);
        send_frame(10'h3C0);
        tx_valid = 1'b1;
        tx_data  = 8'h96;
        tick();
        tx_valid = 1'b0;
        repeat (3) tick();
        #5;
        rst_n  = 1'b0;
        ss_bar = 1'b1;
        #1;
        check("mid_rst_mv",       miso_valid, 1'b0);
        check("mid_rst_miso",     miso,       1'b0);
        check("mid_rst_rx_data",  rx_data,    10'h000);
        check("mid_rst_busy",     busy,       1'b0);
        check("mid_rst_sready",   sready,     1'b1);
        #1;
        rst_n = 1'b1;
        tick();
        push_rx(10'h1F0);
        send_frame(10'h1F0);
        check("post_rst_rx_data", rx_data, 10'h1F0);
        ss_bar = 1'b1;
        tick();

        // Read frame with no tx_valid.
        push_rx(10'h300);
`ifdef SPI_SLAVE_RD_TIMEOUT_EN
        push_bits(8'hFF, 8);
`endif
        send_frame(10'h300);
`ifdef SPI_SLAVE_RD_TIMEOUT_EN
        repeat (15) tick();
        check("to_before_mv", miso_valid, 1'b0);
        tick();
        check("to_first_mv",   miso_valid, 1'b1);
        check("to_first_miso", miso,       1'b1);
        repeat (7) tick();
        check("to_last_mv", miso_valid, 1'b1);
        tick();
        check("to_done_mv", miso_valid, 1'b0);
        check("to_busy",    busy,       1'b1);
`else
        repeat (100) tick();
        check("no_to_busy",   busy,       1'b1);
        check("no_to_mv",     miso_valid, 1'b0);
        check("no_to_sready", sready,     1'b0);
`endif
        ss_bar = 1'b1;
        tick();
        check("final_idle", busy, 1'b0);

        repeat (3) tick();
        check("sb_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
